aead_decrypt_sequencer: RTL and testbench

Session controller for the bit-serial Ascon AEAD decryption core. Each session runs in a fixed order: hold the core in reset, then drive the serial load window, then pulse start and wait for the result. While the core streams plaintext and tag, the block buffers the plaintext and compares the computed tag bit-serially against an expected tag. Plaintext is released only on a full tag match, so unauthenticated data never leaves the block.

---
 rtl/aead_decrypt_sequencer.sv | 174 +++++++++++++++++
 tb/tb_aead_decrypt_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aead_decrypt_sequencer.sv
// Session sequencer for the bit-serial Ascon AEAD decryption core.
// Buffers streamed plaintext and releases it only after a full tag match.
module aead_decrypt_sequencer #(
  parameter int K       = 128,
  parameter int L       = 40,
  parameter int Y       = 40,
  parameter int TAG     = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  output logic load_en,
  output logic core_rst_n,
  output logic core_start,
  input  logic core_ready,
  input  logic core_pt_bit,
  input  logic core_tag_bit,
  input  logic tag_exp_bit,
  output logic pt_valid,
  output logic pt_bit,
  output logic done,
  output logic auth_ok,
  output logic auth_fail,
  output logic err
);

  localparam int KM    = (K > 128) ? K : 128;
  localparam int LY    = (L > Y) ? L : Y;
  localparam int LOADN = (KM > LY) ? KM : LY;
  localparam int N     = (Y > TAG) ? Y : TAG;
  localparam int CM1   = (LOADN + 1 > N) ? LOADN + 1 : N;
  localparam int CMAX  = (CM1 > TIMEOUT) ? CM1 : TIMEOUT;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int YW    = (Y > 1) ? $clog2(Y) : 1;

  localparam logic [CW-1:0] C_LOADN = CW'(LOADN);
  localparam logic [CW-1:0] C_NL    = CW'(N - 1);
  localparam logic [CW-1:0] C_YL    = CW'(Y - 1);
  localparam logic [CW-1:0] C_Y     = CW'(Y);
  localparam logic [CW-1:0] C_TAG   = CW'(TAG);
  localparam logic [CW-1:0] C_TOL   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_STREAM,
    S_REL,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          mis, mis_d;
  logic          ok_d, fail_d, err_d;
  logic          cap;
  logic [Y-1:0]  pbuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mis       <= 1'b0;
      auth_ok   <= 1'b0;
      auth_fail <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mis       <= mis_d;
      auth_ok   <= ok_d;
      auth_fail <= fail_d;
      err       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pbuf <= '0;
    end else if (cap) begin
      pbuf[cnt[YW-1:0]] <= core_pt_bit;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    mis_d      = mis;
    ok_d       = auth_ok;
    fail_d     = auth_fail;
    err_d      = err;
    cap        = 1'b0;
    cmd_ready  = 1'b0;
    load_en    = 1'b0;
    core_rst_n = 1'b1;
    core_start = 1'b0;
    pt_valid   = 1'b0;
    pt_bit     = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready  = 1'b1;
        core_rst_n = 1'b0;
        if (cmd_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          mis_d   = 1'b0;
          ok_d    = 1'b0;
          fail_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // last count is the settle cycle with load_en low
        load_en = (cnt != C_LOADN);
        if (cnt == C_LOADN) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        core_start = 1'b1;
        if (core_ready) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else if (cnt == C_TOL) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          fail_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_STREAM: begin
        cap = (cnt < C_Y);
        if ((cnt < C_TAG) && (core_tag_bit != tag_exp_bit)) begin
          mis_d = 1'b1;
        end
        if (cnt == C_NL) begin
          cnt_d = '0;
          if (mis_d) begin
            state_d = S_DONE;
            fail_d  = 1'b1;
          end else begin
            state_d = S_REL;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_REL: begin
        pt_valid = 1'b1;
        pt_bit   = pbuf[cnt[YW-1:0]];
        if (cnt == C_YL) begin
          state_d = S_DONE;
          ok_d    = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aead_decrypt_sequencer.sv
// Bench for aead_decrypt_sequencer: session-trace model, core model,
// directed pass / fail / timeout / back-to-back / reset scenarios.
module tb_aead_decrypt_sequencer;

  localparam int Y     = 40;
  localparam int TAG   = 128;
  localparam int LOADN = 128;
  localparam int N     = 128;
  localparam int TO    = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic core_ready = 1'b0;
  logic core_pt_bit = 1'b0;
  logic core_tag_bit = 1'b0;
  logic tag_exp_bit = 1'b0;
  logic cmd_ready, load_en, core_rst_n, core_start;
  logic pt_valid, pt_bit, done, auth_ok, auth_fail, err;

  always #5 clk = ~clk;

  aead_decrypt_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .load_en(load_en), .core_rst_n(core_rst_n), .core_start(core_start),
    .core_ready(core_ready), .core_pt_bit(core_pt_bit),
    .core_tag_bit(core_tag_bit), .tag_exp_bit(tag_exp_bit),
    .pt_valid(pt_valid), .pt_bit(pt_bit), .done(done),
    .auth_ok(auth_ok), .auth_fail(auth_fail), .err(err)
  );

  // session configuration shared by the core model and the reference model
  int             c_delay = 20;
  bit             c_tmo = 1'b0;
  logic [Y-1:0]   c_pt = 40'hA5A5A5A5A5;
  logic [TAG-1:0] c_tag = 128'h0123456789ABCDEF_FEDCBA9876543210;
  logic [TAG-1:0] c_mask = '0;

  int checks = 0;
  int passes = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct packed {
    logic rdy, rstn, ld, st, pv, pb, dn, ok, fl, er;
  } vec_t;

  vec_t q[$];
  logic m_ok = 1'b0, m_fl = 1'b0, m_er = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;

  function automatic vec_t busy(logic ld, logic st, logic pv, logic pb);
    vec_t x;
    x = {1'b0, 1'b1, ld, st, pv, pb, 1'b0, 1'b0, 1'b0, 1'b0};
    return x;
  endfunction

  // expected output trace of one whole session, from accept to DONE
  task automatic gen_session();
    vec_t x;
    m_ok = 1'b0; m_fl = 1'b0; m_er = 1'b0;
    for (int d = 0; d < LOADN; d++) q.push_back(busy(1, 0, 0, 0));
    q.push_back(busy(0, 0, 0, 0));
    if (c_tmo) begin
      for (int d = 0; d < TO; d++) q.push_back(busy(0, 1, 0, 0));
      m_fl = 1'b1; m_er = 1'b1;
    end else begin
      for (int d = 0; d < c_delay; d++) q.push_back(busy(0, 1, 0, 0));
      for (int d = 0; d < N; d++) q.push_back(busy(0, 0, 0, 0));
      if (c_mask != '0) begin
        m_fl = 1'b1;
      end else begin
        for (int s = 0; s < Y; s++) q.push_back(busy(0, 0, 1, c_pt[s]));
        m_ok = 1'b1;
      end
    end
    x = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_ok, m_fl, m_er};
    q.push_back(x);
  endtask

  // monitor state read by the directed checks
  int   m_ld = 0, m_st = 0, m_st_first = 0, m_pv = 0, m_dn = 0;
  logic [Y-1:0] m_cap = '0;
  logic d_ok = 1'b0, d_fl = 1'b0, d_er = 1'b0;
  int   low_run = 0, last_low = 0, n_acc = 0;

  always @(negedge clk) begin : compare
    vec_t e, g;
    bit   idle;
    cyc++;
    if (!rst) begin
      q.delete();
      m_ok = 1'b0; m_fl = 1'b0; m_er = 1'b0;
    end
    idle = (q.size() == 0);
    if (idle) e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_ok, m_fl, m_er};
    else      e = q.pop_front();
    g = {cmd_ready, core_rst_n, load_en, core_start, pt_valid, pt_bit,
         done, auth_ok, auth_fail, err};
    if (!e.pv) begin e.pb = 1'b0; g.pb = 1'b0; end
    check($sformatf("cyc%0d_outputs", cyc), 64'(g), 64'(e));

    if (load_en) m_ld++;
    if (core_start) begin
      if (m_st == 0) m_st_first = cyc - acc_cyc;
      m_st++;
    end
    if (pt_valid) begin
      if (m_pv < Y) m_cap[m_pv] = pt_bit;
      m_pv++;
    end
    if (done) begin
      m_dn++;
      d_ok = auth_ok; d_fl = auth_fail; d_er = err;
    end
    if (!core_rst_n) low_run++;
    else begin
      if (low_run != 0) last_low = low_run;
      low_run = 0;
    end
    if (cmd_ready && cmd_valid && rst) n_acc++;

    if (idle && rst && cmd_valid) begin
      gen_session();
      acc_cyc = cyc;
      m_ld = 0; m_st = 0; m_pv = 0; m_cap = '0;
    end
  end

  // core model: ready c_delay cycles into core_start, then streams bits
  int cm_cnt = 0;
  int cm_s = -1;
  always @(posedge clk) begin
    #1;
    if (!core_rst_n) begin
      cm_cnt = 0; cm_s = -1;
      core_ready = 1'b0; core_pt_bit = 1'b0;
      core_tag_bit = 1'b0; tag_exp_bit = 1'b0;
    end else if (core_ready) begin
      cm_s++;
      core_pt_bit = (cm_s < Y) ? c_pt[cm_s] : 1'b0;
      if (cm_s < TAG) begin
        tag_exp_bit  = c_tag[cm_s];
        core_tag_bit = c_tag[cm_s] ^ c_mask[cm_s];
      end
    end else if (core_start && !c_tmo) begin
      cm_cnt++;
      if (cm_cnt == c_delay) core_ready = 1'b1;
    end
  end

  task automatic start_cmd();
    @(posedge clk); #1 cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int d0 = m_dn;
    int k = 0;
    while (m_dn == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (m_dn == d0) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    int d0, n0, k;
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 1);
    check("rst_core_rst_n", 64'(core_rst_n), 0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 1);

    // pass
    start_cmd();
    wait_done("pass", 1000);
    check("pass_load_cycles", m_ld, 128);
    check("pass_start_offset", m_st_first, 130);
    check("pass_start_cycles", m_st, 20);
    check("pass_pv_cycles", m_pv, 40);
    check("pass_plaintext", 64'(m_cap), 64'h00A5A5A5A5A5);
    check("pass_auth_ok", 64'(d_ok), 1);
    check("pass_auth_fail", 64'(d_fl), 0);
    check("pass_err", 64'(d_er), 0);

    // fail on tag bit 127
    c_mask = '0;
    c_mask[127] = 1'b1;
    start_cmd();
    wait_done("fail", 1000);
    check("fail_pv_cycles", m_pv, 0);
    check("fail_auth_fail", 64'(d_fl), 1);
    check("fail_auth_ok", 64'(d_ok), 0);
    check("fail_err", 64'(d_er), 0);

    // timeout
    c_mask = '0;
    c_tmo = 1'b1;
    start_cmd();
    wait_done("tmo", 2000);
    check("tmo_start_cycles", m_st, 1024);
    check("tmo_err", 64'(d_er), 1);
    check("tmo_auth_fail", 64'(d_fl), 1);
    check("tmo_pv_cycles", m_pv, 0);
    c_tmo = 1'b0;

    // back-to-back with cmd_valid held high; first session fails
    c_mask[127] = 1'b1;
    n0 = n_acc;
    @(posedge clk); #1 cmd_valid = 1'b1;
    wait_done("b2b1", 1000);
    check("b2b_single_accept", n_acc - n0, 1);
    c_mask = '0;
    k = 0;
    while (!load_en && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    check("b2b_second_load", 64'(load_en), 1);
    check("b2b_rstn_low_cycles", last_low, 2);
    check("b2b_status_cleared", 64'({auth_ok, auth_fail, err}), 0);
    check("b2b_two_accepts", n_acc - n0, 2);
    cmd_valid = 1'b0;
    wait_done("b2b2", 1000);
    check("b2b_second_ok", 64'(d_ok), 1);

    // reset mid-STREAM at index 10
    start_cmd();
    k = 0;
    while (cm_s != 10 && k < 400) begin
      @(posedge clk); #2;
      k++;
    end
    check("mid_stream_index", cm_s, 10);
    d0 = m_dn;
    #1 rst = 1'b0;
    #1;
    check("async_rst_outputs",
          64'({cmd_ready, core_rst_n, core_start, pt_valid, done}), 64'b10000);
    check("async_rst_status", 64'({auth_ok, auth_fail, err}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("rst_no_release", m_pv, 0);
    check("rst_no_done", m_dn - d0, 0);
    start_cmd();
    wait_done("fresh", 1000);
    check("fresh_auth_ok", 64'(d_ok), 1);
    check("fresh_plaintext", 64'(m_cap), 64'h00A5A5A5A5A5);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
